pulse_stretch: RTL and testbench

Output-side counterpart to the input debouncer. It turns one-clock internal events (instruction fetch, halt, bus write, and so on) into LED pulses long enough for a person to see. Each pulse has a guaranteed minimum on-time and a minimum dark gap before the next, timed by the same slow `clken` tick (1 ms) used for switch conditioning. It sits between core logic and the front-panel LED pins, one instance per indicator.

---
 rtl/pulse_stretch.sv | 196 +++++++++++++++++++
 tb/tb_pulse_stretch.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretch.sv
// pulse_stretch: turns one-clock internal events into LED pulses that are
// long enough to see. Every pulse stays lit for ON_COUNT slow clken ticks
// and is followed by a dark gap of GAP_COUNT ticks before the next pulse.
//
// Optional feature macro: PULSE_STRETCH_QUEUE_EN
//   defined   - events arriving during a pulse or its gap are counted in a
//               saturating pending counter (limit PEND_MAX) and each one is
//               replayed later as its own pulse; an event arriving while
//               the counter is full is discarded with a dropped strobe.
//   undefined - pending is tied to zero; an event during the lit phase
//               restarts the on-time, and an event during the gap is
//               discarded with a dropped strobe.

module pulse_stretch #(
    parameter int ON_COUNT  = 16,
    parameter int GAP_COUNT = 8,
    parameter int PEND_MAX  = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clken,
    input  logic                          trig,
    output logic                          led,
    output logic                          busy,
    output logic [$clog2(PEND_MAX+1)-1:0] pending,
    output logic                          dropped
);

    // The tick counter only has to reach the longer of the two phases.
    localparam int MAX_COUNT = (ON_COUNT > GAP_COUNT) ? ON_COUNT : GAP_COUNT;
    localparam int CNT_W     = $clog2(MAX_COUNT);
    localparam int PEND_W    = $clog2(PEND_MAX + 1);

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_COUNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              led_q;
    logic              led_d;
    logic              busy_q;
    logic              busy_d;
    logic              dropped_q;
    logic              dropped_d;
    logic              queued;

`ifdef PULSE_STRETCH_QUEUE_EN
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    logic [PEND_W-1:0] pending_q;
    logic [PEND_W-1:0] pending_d;
    logic              push;
    logic              pop;

    assign queued  = (pending_q != '0);
    assign pending = pending_q;
`else
    assign queued  = 1'b0;
    assign pending = '0;
`endif

    // Next state, tick counter, event queue and output values for this clock.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        dropped_d = 1'b0;
`ifdef PULSE_STRETCH_QUEUE_EN
        push      = 1'b0;
        pop       = 1'b0;
        pending_d = pending_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // A clken in the same cycle as the event is not counted.
                if (trig) begin
                    state_d = ST_ON;
                    count_d = '0;
                end
            end

            ST_ON: begin
`ifdef PULSE_STRETCH_QUEUE_EN
                push = trig;
                if (clken) begin
                    if (count_q == ON_LAST) begin
                        state_d = ST_GAP;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
`else
                // A new event restarts the on-time and wins over the tick.
                if (trig) begin
                    count_d = '0;
                end else if (clken) begin
                    if (count_q == ON_LAST) begin
                        state_d = ST_GAP;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
`endif
            end

            ST_GAP: begin
                if (clken && (count_q == GAP_LAST)) begin
                    count_d = '0;
                    if (queued) begin
                        // Replay a queued event; a simultaneous new event
                        // takes its place in the queue.
                        state_d = ST_ON;
`ifdef PULSE_STRETCH_QUEUE_EN
                        pop  = 1'b1;
                        push = trig;
`endif
                    end else if (trig) begin
                        state_d = ST_ON;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (clken) begin
                        count_d = count_q + CNT_ONE;
                    end
`ifdef PULSE_STRETCH_QUEUE_EN
                    push = trig;
`else
                    dropped_d = trig;
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

`ifdef PULSE_STRETCH_QUEUE_EN
        // Push and pop together leave the count unchanged, even when full.
        if (push && !pop) begin
            if (pending_q == PEND_FULL) begin
                dropped_d = 1'b1;
            end else begin
                pending_d = pending_q + PEND_ONE;
            end
        end else if (pop && !push) begin
            pending_d = pending_q - PEND_ONE;
        end
`endif

        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
    end

    // Register state, counter, queue and all outputs; reset is synchronous.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
`ifdef PULSE_STRETCH_QUEUE_EN
            pending_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            dropped_q <= dropped_d;
`ifdef PULSE_STRETCH_QUEUE_EN
            pending_q <= pending_d;
`endif
        end
    end

    assign led     = led_q;
    assign busy    = busy_q;
    assign dropped = dropped_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: self-checking bench for pulse_stretch with
// ON_COUNT=4, GAP_COUNT=2, PEND_MAX=2 and clken every 4th clock (or held
// high). A behavioural model tracks remaining ticks per phase and the queued
// event count; outputs are compared against it every cycle, and scenario
// totals (lit ticks, dark ticks, pulses, drops) are checked against
// hand-computed constants. Follows PULSE_STRETCH_QUEUE_EN like the design.

module tb_pulse_stretch;

    localparam int ON_COUNT  = 4;
    localparam int GAP_COUNT = 2;
    localparam int PEND_MAX  = 2;
    localparam int CLKEN_DIV = 4;
    localparam int PEND_W    = $clog2(PEND_MAX + 1);
`ifdef PULSE_STRETCH_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic              clock;
    logic              reset;
    logic              clken;
    logic              trig;
    logic              led;
    logic              busy;
    logic              dropped;
    logic [PEND_W-1:0] pending;

    int errors = 0;
    int checks = 0;
    bit stuck_high = 1'b0;

    // Model: phase flags, ticks still to go in the phase, queued events.
    bit m_busy;
    bit m_lit;
    bit m_drop;
    int m_left;
    int m_pend;

    // Scenario totals measured from DUT and from the model.
    int dut_lit_ticks, dut_gap_ticks, dut_pulses, dut_drops, dut_led_clks, dut_dark_clks;
    int mdl_lit_ticks, mdl_gap_ticks, mdl_pulses, mdl_drops, mdl_led_clks, mdl_dark_clks;
    bit dut_led_prev, mdl_led_prev;

    pulse_stretch #(
        .ON_COUNT (ON_COUNT),
        .GAP_COUNT(GAP_COUNT),
        .PEND_MAX (PEND_MAX)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .clken  (clken),
        .trig   (trig),
        .led    (led),
        .busy   (busy),
        .pending(pending),
        .dropped(dropped)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Slow tick: one clock high out of every CLKEN_DIV, or stuck high.
    initial begin
        int div;
        div   = 0;
        clken = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            div   = (div + 1) % CLKEN_DIV;
            clken = stuck_high || (div == 0);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_queue_event();
        if (m_pend < PEND_MAX) m_pend++;
        else m_drop = 1'b1;
    endtask

    task automatic model_step();
        bit t;
        bit c;
        t = trig;
        c = clken;
        m_drop = 1'b0;
        if (reset) begin
            m_busy = 1'b0;
            m_lit  = 1'b0;
            m_left = 0;
            m_pend = 0;
        end else if (!m_busy) begin
            if (t) begin
                m_busy = 1'b1;
                m_lit  = 1'b1;
                m_left = ON_COUNT;
            end
        end else if (m_lit) begin
            if (QUEUE && t) model_queue_event();
            if (!QUEUE && t) begin
                m_left = ON_COUNT;
            end else if (c) begin
                m_left--;
                if (m_left == 0) begin
                    m_lit  = 1'b0;
                    m_left = GAP_COUNT;
                end
            end
        end else begin
            if (c && m_left == 1) begin
                if (m_pend > 0) begin
                    m_lit  = 1'b1;
                    m_left = ON_COUNT;
                    if (!t) m_pend--;
                end else if (t) begin
                    m_lit  = 1'b1;
                    m_left = ON_COUNT;
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                if (c) m_left--;
                if (t) begin
                    if (QUEUE) model_queue_event();
                    else m_drop = 1'b1;
                end
            end
        end
    endtask

    initial begin
        m_busy = 1'b0;
        m_lit  = 1'b0;
        m_drop = 1'b0;
        m_left = 0;
        m_pend = 0;
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    // Per-cycle comparison against the model plus scenario tallies.
    initial begin
        forever begin
            @(negedge clock);
            checkOutput("led", led, m_lit);
            checkOutput("busy", busy, m_busy);
            checkOutput("pending", pending, m_pend);
            checkOutput("dropped", dropped, m_drop);
            if (clken && led) dut_lit_ticks++;
            if (clken && busy && !led) dut_gap_ticks++;
            if (led && !dut_led_prev) dut_pulses++;
            if (dropped) dut_drops++;
            if (led) dut_led_clks++;
            if (busy && !led) dut_dark_clks++;
            dut_led_prev = led;
            if (clken && m_lit) mdl_lit_ticks++;
            if (clken && m_busy && !m_lit) mdl_gap_ticks++;
            if (m_lit && !mdl_led_prev) mdl_pulses++;
            if (m_drop) mdl_drops++;
            if (m_lit) mdl_led_clks++;
            if (m_busy && !m_lit) mdl_dark_clks++;
            mdl_led_prev = m_lit;
        end
    end

    task automatic clear_counts();
        dut_lit_ticks = 0; dut_gap_ticks = 0; dut_pulses = 0; dut_drops = 0;
        dut_led_clks = 0; dut_dark_clks = 0; dut_led_prev = 1'b0;
        mdl_lit_ticks = 0; mdl_gap_ticks = 0; mdl_pulses = 0; mdl_drops = 0;
        mdl_led_clks = 0; mdl_dark_clks = 0; mdl_led_prev = 1'b0;
    endtask

    // One-cycle event strobe; returns at the negedge after the sampling edge.
    task automatic applyStimulus();
        @(negedge clock);
        trig = 1'b1;
        @(negedge clock);
        trig = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (m_busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (m_busy) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle: still busy after %0d cycles", budget);
        end
        repeat (2) @(negedge clock);
    endtask

    // Wait for a negedge where the given phase, ticks-left and clken hold.
    task automatic wait_phase(input bit want_lit, input int left, input bit want_clken, input string name, input int budget);
        int n = 0;
        while (!(m_busy && m_lit == want_lit && m_left == left && clken == want_clken) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: condition not reached in %0d cycles", name, budget);
        end
    endtask

    task automatic check_totals(input string tag, input int lit, input int gap, input int pulses, input int drops);
        checkOutput({tag, "_lit_ticks"}, dut_lit_ticks, lit);
        checkOutput({tag, "_gap_ticks"}, dut_gap_ticks, gap);
        checkOutput({tag, "_pulses"}, dut_pulses, pulses);
        checkOutput({tag, "_drops"}, dut_drops, drops);
        checkOutput({tag, "_model_lit_ticks"}, mdl_lit_ticks, lit);
        checkOutput({tag, "_model_gap_ticks"}, mdl_gap_ticks, gap);
        checkOutput({tag, "_model_pulses"}, mdl_pulses, pulses);
        checkOutput({tag, "_model_drops"}, mdl_drops, drops);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        trig  = 1'b0;
        clear_counts();
        repeat (3) @(negedge clock);
        checkOutput("reset_led", led, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_pending", pending, 0);
        checkOutput("reset_dropped", dropped, 0);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] single event from idle");
        clear_counts();
        applyStimulus();
        checkOutput("single_led_rise", led, 1);
        wait_idle(200);
        check_totals("single", 4, 2, 1, 0);

`ifdef PULSE_STRETCH_QUEUE_EN
        $display("[TB] three events during one lit phase");
        clear_counts();
        applyStimulus();
        applyStimulus();
        checkOutput("queue_pend_1", pending, 1);
        checkOutput("queue_drop_1", dropped, 0);
        applyStimulus();
        checkOutput("queue_pend_2", pending, 2);
        checkOutput("queue_drop_2", dropped, 0);
        applyStimulus();
        checkOutput("queue_pend_3", pending, 2);
        checkOutput("queue_drop_3", dropped, 1);
        wait_idle(400);
        checkOutput("queue_end_pending", pending, 0);
        check_totals("queue", 12, 6, 3, 1);
`else
        $display("[TB] retrigger on third lit tick, then event in gap");
        clear_counts();
        applyStimulus();
        wait_phase(1'b1, 2, 1'b1, "retrig_point", 100);
        trig = 1'b1;
        @(negedge clock);
        trig = 1'b0;
        checkOutput("retrig_led_held", led, 1);
        wait_phase(1'b0, GAP_COUNT, 1'b0, "gap_entry", 100);
        trig = 1'b1;
        @(negedge clock);
        trig = 1'b0;
        checkOutput("gap_event_dropped", dropped, 1);
        checkOutput("gap_event_led", led, 0);
        wait_idle(200);
        check_totals("retrig", 7, 2, 1, 1);
`endif

        $display("[TB] event coincident with gap expiry");
        clear_counts();
        applyStimulus();
        wait_phase(1'b0, 1, 1'b1, "gap_expiry", 100);
        trig = 1'b1;
        @(negedge clock);
        trig = 1'b0;
        checkOutput("expiry_led", led, 1);
        checkOutput("expiry_busy", busy, 1);
        checkOutput("expiry_pending", pending, 0);
        checkOutput("expiry_dropped", dropped, 0);
        wait_idle(200);
        check_totals("expiry", 8, 4, 2, 0);

        $display("[TB] reset during lit phase");
        clear_counts();
        applyStimulus();
`ifdef PULSE_STRETCH_QUEUE_EN
        applyStimulus();
        applyStimulus();
        checkOutput("rst_pending_before", pending, 2);
`endif
        checkOutput("rst_led_before", led, 1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("rst_led", led, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pending", pending, 0);
        checkOutput("rst_dropped", dropped, 0);
        applyStimulus();
        checkOutput("rst_after_led", led, 1);
        checkOutput("rst_after_busy", busy, 1);
        wait_idle(200);
        checkOutput("rst_pulses", dut_pulses, 2);
        checkOutput("rst_drops", dut_drops, 0);

        $display("[TB] clken held high");
        stuck_high = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("stuck_idle_busy", busy, 0);
        clear_counts();
        applyStimulus();
        wait_idle(50);
        checkOutput("stuck_led_clks", dut_led_clks, 4);
        checkOutput("stuck_dark_clks", dut_dark_clks, 2);
        checkOutput("stuck_model_led_clks", mdl_led_clks, 4);
        checkOutput("stuck_model_dark_clks", mdl_dark_clks, 2);
        check_totals("stuck", 4, 2, 1, 0);
        stuck_high = 1'b0;
        repeat (4) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
